szg_i2s2_capture_ctrl: RTL

Sequencing controller between the I2S2 PMOD PHY and the FrontPanel readout path. It detects each completed stereo frame from the PHY, forms one signed 24-bit sample per frame (mono mix, left or right), and captures a host-requested number of samples, optionally gated by a level trigger. Samples are delivered on a valid/ready stream. Status is reported to FrontPanel wires: busy, done and a sticky overflow flag.

---
 rtl/szg_i2s2_pkg.sv | 19 +
 rtl/szg_i2s2_mixer.sv | 58 +++++
 rtl/szg_i2s2_capture_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/szg_i2s2_pkg.sv
// Shared types and constants for the I2S2 capture path.
// Mode encoding 2'b11 is treated as mono alongside MODE_MONO.
package szg_i2s2_pkg;

  localparam int DEFAULT_SAMPLE_W = 24;
  localparam int DEFAULT_COUNT_W  = 16;

  localparam logic [1:0] MODE_MONO  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_ARMED,
    CAP_CAPTURE,
    CAP_DONE
  } cap_state_t;

endpackage

// File: rtl/szg_i2s2_mixer.sv
// Detects each lrck rising edge and forms one signed sample per stereo frame.
// sample/sample_stb appear the cycle after the frame strobe.
module szg_i2s2_mixer
  import szg_i2s2_pkg::*;
#(
  parameter int SAMPLE_W = DEFAULT_SAMPLE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lrck,
  input  logic [SAMPLE_W-1:0] l_channel,
  input  logic [SAMPLE_W-1:0] r_channel,
  input  logic [1:0]          mode,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_stb
);

  logic                 lrck_q;
  logic                 frame;
  logic signed [SAMPLE_W:0] sum;
  logic [SAMPLE_W-1:0]  mono;
  logic [SAMPLE_W-1:0]  sel;
  logic [SAMPLE_W-1:0]  sample_d, sample_q;
  logic                 stb_d, stb_q;

  always_comb begin
    frame = lrck & ~lrck_q;
    // One extra bit keeps the sum exact; the arithmetic shift gives floor((L+R)/2).
    sum   = $signed({l_channel[SAMPLE_W-1], l_channel})
          + $signed({r_channel[SAMPLE_W-1], r_channel});
    mono  = SAMPLE_W'(sum >>> 1);
    case (mode)
      MODE_MONO:  sel = mono;
      MODE_LEFT:  sel = l_channel;
      MODE_RIGHT: sel = r_channel;
      default:    sel = mono;
    endcase
    sample_d = frame ? sel : sample_q;
    stb_d    = frame;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lrck_q   <= 1'b0;
      sample_q <= '0;
      stb_q    <= 1'b0;
    end else begin
      lrck_q   <= lrck;
      sample_q <= sample_d;
      stb_q    <= stb_d;
    end
  end

  assign sample     = sample_q;
  assign sample_stb = stb_q;

endmodule

// File: rtl/szg_i2s2_capture_ctrl.sv
// Capture sequencer: optional level trigger, counted capture, valid/ready output
// register that never overwrites a held sample, and FrontPanel status flags.
module szg_i2s2_capture_ctrl
  import szg_i2s2_pkg::*;
#(
  parameter int SAMPLE_W = DEFAULT_SAMPLE_W,
  parameter int COUNT_W  = DEFAULT_COUNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lrck,
  input  logic [SAMPLE_W-1:0] l_channel,
  input  logic [SAMPLE_W-1:0] r_channel,
  input  logic [1:0]          mode,
  input  logic                start,
  input  logic                abort,
  input  logic [COUNT_W-1:0]  num_samples,
  input  logic                trig_en,
  input  logic [SAMPLE_W-1:0] trig_level,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  logic [SAMPLE_W-1:0] sample;
  logic                sample_stb;

  szg_i2s2_mixer #(.SAMPLE_W(SAMPLE_W)) u_mixer (
    .clk        (clk),
    .reset      (reset),
    .lrck       (lrck),
    .l_channel  (l_channel),
    .r_channel  (r_channel),
    .mode       (mode),
    .sample     (sample),
    .sample_stb (sample_stb)
  );

  cap_state_t          state_d, state_q;
  logic [SAMPLE_W-1:0] out_data_d, out_data_q;
  logic                out_valid_d, out_valid_q;
  logic                busy_d, busy_q;
  logic                done_d, done_q;
  logic                overflow_d, overflow_q;
  logic [COUNT_W-1:0]  count_d, count_q;
  logic [COUNT_W-1:0]  num_d, num_q;
  logic [SAMPLE_W-1:0] level_d, level_q;
  logic [SAMPLE_W-1:0] mag;
  logic                hs;
  logic                accept_start;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    overflow_d   = overflow_q;
    count_d      = count_q;
    num_d        = num_q;
    level_d      = level_q;
    mag          = sample[SAMPLE_W-1] ? -sample : sample;
    hs           = out_valid_q & out_ready;
    accept_start = start && (num_samples != '0);

    if (abort) begin
      state_d     = CAP_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        CAP_IDLE, CAP_DONE: begin
          if (accept_start) begin
            num_d      = num_samples;
            level_d    = trig_level;
            overflow_d = 1'b0;
            count_d    = '0;
            state_d    = trig_en ? CAP_ARMED : CAP_CAPTURE;
          end
        end
        CAP_ARMED: begin
          // The triggering sample is itself the first captured sample.
          if (sample_stb && (mag >= level_q)) begin
            out_data_d  = sample;
            out_valid_d = 1'b1;
            count_d     = count_q + COUNT_W'(1);
            state_d     = CAP_CAPTURE;
          end
        end
        CAP_CAPTURE: begin
          if (hs) out_valid_d = 1'b0;
          if (hs && (count_q == num_q)) begin
            state_d = CAP_DONE;
          end else if (sample_stb && (count_q != num_q)) begin
            if (out_valid_q && !out_ready) begin
              overflow_d = 1'b1;
            end else begin
              out_data_d  = sample;
              out_valid_d = 1'b1;
              count_d     = count_q + COUNT_W'(1);
            end
          end
        end
        default: state_d = CAP_IDLE;
      endcase
    end

    busy_d = (state_d == CAP_ARMED) || (state_d == CAP_CAPTURE);
    done_d = (state_d == CAP_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= CAP_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
      num_q       <= '0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
      num_q       <= num_d;
      level_q     <= level_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule
